// File: rtl/msp430_multiplier_iter_if.sv
// ---------------------------------------------------------------------------
// msp430_multiplier_iter_if
// MSP430 peripheral bus bundle for the iterative multiplier.
//   per_addr : word address driven by the CPU side
//   per_din  : write data
//   per_en   : bus enable
//   per_we   : byte write enables (00 = read)
//   per_dout : read data returned by the peripheral
// master = CPU/bus side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface msp430_multiplier_iter_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (
    output per_addr,
    output per_din,
    output per_en,
    output per_we,
    input  per_dout
  );

  modport slave (
    input  per_addr,
    input  per_din,
    input  per_en,
    input  per_we,
    output per_dout
  );
endinterface

// File: rtl/msp430_multiplier_iter.sv
// ---------------------------------------------------------------------------
// msp430_multiplier_iter
// Iterative 16x16 multiplier / multiply-accumulate peripheral on the MSP430
// peripheral bus. op2 is consumed SLICE_W bits per cycle, so one operation
// takes N = 16/SLICE_W cycles. Supports signed/unsigned MPY and MAC,
// Q15 fractional mode and signed saturation, plus a BUSY/ERR protocol.
//   mclk     : main clock
//   puc_rst  : synchronous active-high reset
//   bus      : peripheral bus (slave modport); per_dout is combinational
// Register map (byte offsets): 0x0 MPY, 0x2 MPYS, 0x4 MAC, 0x6 MACS,
// 0x8 OP2, 0xA RESLO, 0xC RESHI, 0xE SUMEXT, 0x10 CTL.
// CTL: bit0 FRAC, bit1 SAT, bit2 BUSY (ro), bit3 ERR (write 1 to clear).
// ---------------------------------------------------------------------------
module msp430_multiplier_iter #(
  parameter logic [14:0] BASE_ADDR = 15'h0140,
  parameter int          DEC_WD    = 5,
  parameter int          SLICE_W   = 8
) (
  input  logic                           mclk,
  input  logic                           puc_rst,
  msp430_multiplier_iter_if.slave        bus
);

  localparam int N     = 16 / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = DEC_WD - 1;

  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

  localparam logic [IDX_W-1:0] R_MPY    = IDX_W'(0);
  localparam logic [IDX_W-1:0] R_MPYS   = IDX_W'(1);
  localparam logic [IDX_W-1:0] R_MAC    = IDX_W'(2);
  localparam logic [IDX_W-1:0] R_MACS   = IDX_W'(3);
  localparam logic [IDX_W-1:0] R_OP2    = IDX_W'(4);
  localparam logic [IDX_W-1:0] R_RESLO  = IDX_W'(5);
  localparam logic [IDX_W-1:0] R_RESHI  = IDX_W'(6);
  localparam logic [IDX_W-1:0] R_SUMEXT = IDX_W'(7);
  localparam logic [IDX_W-1:0] R_CTL    = IDX_W'(8);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Architectural state
  logic [15:0]      op1_r;
  logic [15:0]      op2_r;
  logic [31:0]      res_r;
  logic [15:0]      sumext_r;
  logic             sign_sel_r;
  logic             acc_sel_r;
  logic             frac_r;
  logic             sat_r;
  logic             err_r;
  logic             frac_run_r;
  logic             sat_run_r;
  logic [CNT_W-1:0] k_r;
  logic [32:0]      prod_r;

  // Bus decode
  logic             sel_s;
  logic             wr_s;
  logic             rd_s;
  logic [IDX_W-1:0] idx_s;
  logic [15:0]      din_s;
  logic             wr_op1_s;
  logic             wr_op2_s;
  logic             wr_reslo_s;
  logic             wr_reshi_s;
  logic             wr_ctl_s;
  logic             start_s;
  logic             err_set_s;
  logic             busy_s;
  logic             last_s;
  logic             fwd_s;
  logic [15:0]      dout_s;

  // Datapath
  logic [3:0]                 shamt_s;
  logic [SLICE_W-1:0]         slice_raw_s;
  logic [SLICE_W:0]           slice_x_s;
  logic [16:0]                op1_x_s;
  logic signed [17+SLICE_W:0] pp_s;
  logic [32:0]                pp_ext_s;
  logic [32:0]                prod_fin_s;
  logic [33:0]                prod_adj_s;
  logic [34:0]                wide_s;
  logic [32:0]                sum_u_s;
  logic                       ovf_s;
  logic [31:0]                res_nxt_s;
  logic [15:0]                sumext_nxt_s;

  assign sel_s  = (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign idx_s  = bus.per_addr[DEC_WD-2:0];
  assign wr_s   = bus.per_en & sel_s & (|bus.per_we);
  assign rd_s   = bus.per_en & sel_s & ~(|bus.per_we);
  assign din_s  = {(bus.per_we[1] ? bus.per_din[15:8] : 8'h00), bus.per_din[7:0]};

  assign busy_s    = (state_r == ST_RUN);
  assign last_s    = (k_r == K_LAST);
  assign fwd_s     = busy_s & last_s;
  assign start_s   = wr_op2_s & ~busy_s;
  assign err_set_s = busy_s & (wr_op1_s | wr_op2_s | wr_reslo_s | wr_reshi_s);

  // Write-strobe decode per register
  always_comb begin
    wr_op1_s   = 1'b0;
    wr_op2_s   = 1'b0;
    wr_reslo_s = 1'b0;
    wr_reshi_s = 1'b0;
    wr_ctl_s   = 1'b0;
    if (wr_s) begin
      case (idx_s)
        R_MPY, R_MPYS, R_MAC, R_MACS: wr_op1_s   = 1'b1;
        R_OP2:                        wr_op2_s   = 1'b1;
        R_RESLO:                      wr_reslo_s = 1'b1;
        R_RESHI:                      wr_reshi_s = 1'b1;
        R_CTL:                        wr_ctl_s   = 1'b1;
        default:                      wr_ctl_s   = 1'b0;
      endcase
    end else begin
      wr_ctl_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_RUN;
        else         state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Slice multiply, final product shaping, accumulation and saturation
  always_comb begin
    shamt_s     = 4'(32'(k_r) * SLICE_W);
    slice_raw_s = op2_r[shamt_s +: SLICE_W];
    // Only the top slice carries the op2 sign; lower slices are magnitudes.
    slice_x_s   = {(last_s & sign_sel_r & slice_raw_s[SLICE_W-1]), slice_raw_s};
    op1_x_s     = {(sign_sel_r & op1_r[15]), op1_r};
    pp_s        = $signed({{(SLICE_W+1){op1_x_s[16]}}, op1_x_s}) *
                  $signed({{17{slice_x_s[SLICE_W]}}, slice_x_s});
    pp_ext_s    = 33'(pp_s);
    prod_fin_s  = prod_r + (pp_ext_s << shamt_s);

    if (frac_run_r && sign_sel_r) begin
      prod_adj_s = {prod_fin_s, 1'b0};
    end else begin
      prod_adj_s = {prod_fin_s[32], prod_fin_s};
    end

    // Wide signed sum so that overflow past 32 bits is visible.
    wide_s  = {{3{res_r[31]}}, res_r} + {prod_adj_s[33], prod_adj_s};
    ovf_s   = ~((wide_s[34:31] == 4'h0) || (wide_s[34:31] == 4'hF));
    sum_u_s = {1'b0, res_r} + {1'b0, prod_fin_s[31:0]};

    if (sign_sel_r) begin
      if (sat_run_r && ovf_s) begin
        res_nxt_s = wide_s[34] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        res_nxt_s = wide_s[31:0];
      end
      sumext_nxt_s = res_nxt_s[31] ? 16'hFFFF : 16'h0000;
    end else begin
      res_nxt_s = sum_u_s[31:0];
      if (acc_sel_r) begin
        sumext_nxt_s = {15'h0000, (sum_u_s[32] | sumext_r[0])};
      end else begin
        sumext_nxt_s = 16'h0000;
      end
    end
  end

  // Register file, iteration counter and partial-product accumulator
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      op1_r      <= 16'h0000;
      op2_r      <= 16'h0000;
      res_r      <= 32'h0000_0000;
      sumext_r   <= 16'h0000;
      sign_sel_r <= 1'b0;
      acc_sel_r  <= 1'b0;
      frac_r     <= 1'b0;
      sat_r      <= 1'b0;
      err_r      <= 1'b0;
      frac_run_r <= 1'b0;
      sat_run_r  <= 1'b0;
      k_r        <= '0;
      prod_r     <= 33'h0_0000_0000;
    end else begin
      if (wr_op1_s && !busy_s) begin
        op1_r      <= din_s;
        // Alias index bit0 selects signed, bit1 selects accumulate.
        sign_sel_r <= idx_s[0];
        acc_sel_r  <= idx_s[1];
      end

      if (start_s) begin
        op2_r      <= din_s;
        sumext_r   <= 16'h0000;
        frac_run_r <= frac_r;
        sat_run_r  <= sat_r;
        k_r        <= '0;
        prod_r     <= 33'h0_0000_0000;
        if (!acc_sel_r) begin
          res_r <= 32'h0000_0000;
        end
      end else if (busy_s) begin
        if (last_s) begin
          res_r    <= res_nxt_s;
          sumext_r <= sumext_nxt_s;
          k_r      <= '0;
          prod_r   <= 33'h0_0000_0000;
        end else begin
          k_r    <= k_r + CNT_W'(1);
          prod_r <= prod_fin_s;
        end
      end else if (wr_reslo_s) begin
        res_r[15:0] <= din_s;
      end else if (wr_reshi_s) begin
        res_r[31:16] <= din_s;
      end

      if (wr_ctl_s) begin
        frac_r <= din_s[0];
        sat_r  <= din_s[1];
      end

      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (wr_ctl_s && din_s[3]) begin
        err_r <= 1'b0;
      end
    end
  end

  // Read mux; results are forwarded during the final RUN cycle
  always_comb begin
    dout_s = 16'h0000;
    if (rd_s) begin
      case (idx_s)
        R_MPY, R_MPYS, R_MAC, R_MACS: dout_s = op1_r;
        R_OP2:    dout_s = op2_r;
        R_RESLO:  dout_s = fwd_s ? res_nxt_s[15:0]  : res_r[15:0];
        R_RESHI:  dout_s = fwd_s ? res_nxt_s[31:16] : res_r[31:16];
        R_SUMEXT: dout_s = fwd_s ? sumext_nxt_s     : sumext_r;
        R_CTL:    dout_s = {12'h000, err_r, busy_s, sat_r, frac_r};
        default:  dout_s = 16'h0000;
      endcase
    end else begin
      dout_s = 16'h0000;
    end
  end

  assign bus.per_dout = dout_s;

endmodule

// File: tb/tb_msp430_multiplier_iter.sv
// ---------------------------------------------------------------------------
// tb_msp430_multiplier_iter
// Drives three multiplier instances (SLICE_W = 8, 1, 16) from one bus and
// checks them against an arithmetic reference model plus directed values.
// ---------------------------------------------------------------------------
module tb_msp430_multiplier_iter;

  localparam logic [3:0] R_MPY    = 4'd0;
  localparam logic [3:0] R_MPYS   = 4'd1;
  localparam logic [3:0] R_MAC    = 4'd2;
  localparam logic [3:0] R_MACS   = 4'd3;
  localparam logic [3:0] R_OP2    = 4'd4;
  localparam logic [3:0] R_RESLO  = 4'd5;
  localparam logic [3:0] R_RESHI  = 4'd6;
  localparam logic [3:0] R_SUMEXT = 4'd7;
  localparam logic [3:0] R_CTL    = 4'd8;

  logic mclk = 1'b0;
  logic puc_rst;

  msp430_multiplier_iter_if bus8 ();
  msp430_multiplier_iter_if bus1 ();
  msp430_multiplier_iter_if bus16 ();

  assign bus1.per_addr  = bus8.per_addr;
  assign bus1.per_din   = bus8.per_din;
  assign bus1.per_en    = bus8.per_en;
  assign bus1.per_we    = bus8.per_we;
  assign bus16.per_addr = bus8.per_addr;
  assign bus16.per_din  = bus8.per_din;
  assign bus16.per_en   = bus8.per_en;
  assign bus16.per_we   = bus8.per_we;

  msp430_multiplier_iter #(.BASE_ADDR(15'h0140), .DEC_WD(5), .SLICE_W(8))
    dut8 (.mclk(mclk), .puc_rst(puc_rst), .bus(bus8));
  msp430_multiplier_iter #(.BASE_ADDR(15'h0140), .DEC_WD(5), .SLICE_W(1))
    dut1 (.mclk(mclk), .puc_rst(puc_rst), .bus(bus1));
  msp430_multiplier_iter #(.BASE_ADDR(15'h0140), .DEC_WD(5), .SLICE_W(16))
    dut16 (.mclk(mclk), .puc_rst(puc_rst), .bus(bus16));

  always #5 mclk = ~mclk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] r8, r1, r16;

  // Reference model state
  logic [15:0] m_op1, m_op2, m_sumext;
  logic [31:0] m_res;
  logic        m_sign, m_acc, m_frac, m_sat, m_err;

  function automatic void model_reset();
    m_op1 = 16'h0000; m_op2 = 16'h0000; m_sumext = 16'h0000;
    m_res = 32'h0000_0000;
    m_sign = 1'b0; m_acc = 1'b0; m_frac = 1'b0; m_sat = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_op1(input logic [3:0] alias_idx, input logic [15:0] v);
    m_op1  = v;
    m_sign = (alias_idx == R_MPYS) || (alias_idx == R_MACS);
    m_acc  = (alias_idx == R_MAC)  || (alias_idx == R_MACS);
  endfunction

  // Plain integer arithmetic: full product, optional Q15 doubling, accumulate, clamp.
  function automatic void model_start(input logic [15:0] op2);
    longint a, b, p, r;
    m_op2 = op2;
    a = m_sign ? longint'($signed(m_op1)) : longint'(m_op1);
    b = m_sign ? longint'($signed(op2))   : longint'(op2);
    p = a * b;
    if (m_sign && m_frac) p = p * 64'sd2;
    if (m_sign) begin
      r = (m_acc ? longint'($signed(m_res)) : 64'sd0) + p;
      if (m_sat && (r > 64'sh0000_0000_7FFF_FFFF)) r = 64'sh0000_0000_7FFF_FFFF;
      if (m_sat && (r < -64'sh0000_0000_8000_0000)) r = -64'sh0000_0000_8000_0000;
      m_res    = r[31:0];
      m_sumext = m_res[31] ? 16'hFFFF : 16'h0000;
    end else begin
      r = (m_acc ? longint'(m_res) : 64'sd0) + p;
      m_res    = r[31:0];
      m_sumext = (m_acc && r[32]) ? 16'h0001 : 16'h0000;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] idx, input logic [15:0] data, input logic [1:0] we);
    @(negedge mclk);
    bus8.per_addr = 14'h00A0 + {10'h000, idx};
    bus8.per_din  = data;
    bus8.per_we   = we;
    bus8.per_en   = 1'b1;
    @(posedge mclk);
    #1;
    bus8.per_en = 1'b0;
    bus8.per_we = 2'b00;
  endtask

  task automatic bus_rd_addr(input logic [13:0] addr);
    @(negedge mclk);
    bus8.per_addr = addr;
    bus8.per_we   = 2'b00;
    bus8.per_en   = 1'b1;
    #1;
    r8  = bus8.per_dout;
    r1  = bus1.per_dout;
    r16 = bus16.per_dout;
    @(posedge mclk);
    #1;
    bus8.per_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] idx);
    bus_rd_addr(14'h00A0 + {10'h000, idx});
  endtask

  task automatic chk3(input string tag, input logic [3:0] idx, input logic [15:0] exp);
    bus_rd(idx);
    chk({tag, "/sw8"},  r8,  exp);
    chk({tag, "/sw1"},  r1,  exp);
    chk({tag, "/sw16"}, r16, exp);
  endtask

  task automatic count_busy(output int c8, output int c1, output int c16, output bit done);
    c8 = 0; c1 = 0; c16 = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      bus_rd(R_CTL);
      if (r8[2])  c8++;
      if (r1[2])  c1++;
      if (r16[2]) c16++;
      done = !(r8[2] | r1[2] | r16[2]);
    end
  endtask

  task automatic wait_idle();
    int c8, c1, c16;
    bit done;
    count_busy(c8, c1, c16, done);
    chk("idle_timeout", {15'h0000, ~done}, 16'h0000);
  endtask

  task automatic check_results(input string tag);
    chk3({tag, "_reslo"},  R_RESLO,  m_res[15:0]);
    chk3({tag, "_reshi"},  R_RESHI,  m_res[31:16]);
    chk3({tag, "_sumext"}, R_SUMEXT, m_sumext);
  endtask

  task automatic run_op(input logic [3:0] alias_idx, input logic [15:0] a, input logic [15:0] b);
    bus_wr(alias_idx, a, 2'b11);
    model_op1(alias_idx, a);
    bus_wr(R_OP2, b, 2'b11);
    model_start(b);
    wait_idle();
  endtask

  function automatic logic [15:0] pick16();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h8000;
      1:       v = 16'hFFFF;
      2:       v = 16'h7FFF;
      3:       v = 16'h0001;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int c8, c1, c16;
    bit done;
    logic [15:0] v;
    logic [3:0]  a;

    bus8.per_addr = 14'h0000;
    bus8.per_din  = 16'h0000;
    bus8.per_en   = 1'b0;
    bus8.per_we   = 2'b00;
    puc_rst = 1'b1;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    puc_rst = 1'b0;

    // Reset state
    for (int i = 0; i <= 8; i++) chk3("reset", 4'(i), 16'h0000);

    // Unsigned MPY with busy-length check on every slice width
    bus_wr(R_MPY, 16'hFFFF, 2'b11);
    model_op1(R_MPY, 16'hFFFF);
    bus_wr(R_OP2, 16'hFFFF, 2'b11);
    model_start(16'hFFFF);
    count_busy(c8, c1, c16, done);
    chk("busy_cycles/sw8",  16'(c8),  16'd2);
    chk("busy_cycles/sw1",  16'(c1),  16'd16);
    chk("busy_cycles/sw16", 16'(c16), 16'd1);
    chk3("mpy_ffff_reshi",  R_RESHI,  16'hFFFE);
    chk3("mpy_ffff_reslo",  R_RESLO,  16'h0001);
    chk3("mpy_ffff_sumext", R_SUMEXT, 16'h0000);

    // Signed MPYS with forwarded read in the final RUN cycle
    bus_wr(R_MPYS, 16'hFFFF, 2'b11);
    model_op1(R_MPYS, 16'hFFFF);
    bus_wr(R_OP2, 16'h0002, 2'b11);
    model_start(16'h0002);
    bus_rd(R_RESLO);
    chk("fwd_c1/sw8",  r8,  16'h0000);
    chk("fwd_c1/sw1",  r1,  16'h0000);
    chk("fwd_c1/sw16", r16, 16'hFFFE);
    bus_rd(R_RESLO);
    chk("fwd_c2/sw8",  r8,  16'hFFFE);
    chk("fwd_c2/sw1",  r1,  16'h0000);
    wait_idle();
    chk3("mpys_reshi",  R_RESHI,  16'hFFFF);
    chk3("mpys_reslo",  R_RESLO,  16'hFFFE);
    chk3("mpys_sumext", R_SUMEXT, 16'hFFFF);

    // Signed MAC onto previous result
    run_op(R_MACS, 16'h0003, 16'h0001);
    chk3("macs_reshi",  R_RESHI,  16'h0000);
    chk3("macs_reslo",  R_RESLO,  16'h0001);
    chk3("macs_sumext", R_SUMEXT, 16'h0000);

    // Unsigned carry out of the accumulator
    bus_wr(R_RESLO, 16'hFFFF, 2'b11);
    bus_wr(R_RESHI, 16'hFFFF, 2'b11);
    m_res = 32'hFFFF_FFFF;
    chk3("direct_reslo", R_RESLO, 16'hFFFF);
    run_op(R_MAC, 16'h0001, 16'h0001);
    chk3("carry_reshi",  R_RESHI,  16'h0000);
    chk3("carry_reslo",  R_RESLO,  16'h0000);
    chk3("carry_sumext", R_SUMEXT, 16'h0001);

    // Fractional + saturation, then fractional without saturation
    bus_wr(R_CTL, 16'h0003, 2'b11);
    m_frac = 1'b1; m_sat = 1'b1;
    run_op(R_MPYS, 16'h8000, 16'h8000);
    chk3("fracsat_reshi",  R_RESHI,  16'h7FFF);
    chk3("fracsat_reslo",  R_RESLO,  16'hFFFF);
    chk3("fracsat_sumext", R_SUMEXT, 16'h0000);
    bus_wr(R_CTL, 16'h0001, 2'b11);
    m_sat = 1'b0;
    run_op(R_MPYS, 16'h8000, 16'h8000);
    chk3("frac_reshi", R_RESHI, 16'h8000);
    chk3("frac_reslo", R_RESLO, 16'h0000);
    chk3("ctl_frac",   R_CTL,   16'h0001);

    // OP1 write while busy is dropped and flags ERR; W1C clears it
    bus_wr(R_MPY, 16'h1234, 2'b11);
    model_op1(R_MPY, 16'h1234);
    bus_wr(R_OP2, 16'h0005, 2'b11);
    model_start(16'h0005);
    bus_wr(R_MPY, 16'h5678, 2'b11);
    wait_idle();
    chk3("busy_op1_kept", R_MPY, 16'h1234);
    chk3("err_set",       R_CTL, 16'h0009);
    check_results("busy_drop");
    bus_wr(R_CTL, 16'h0008, 2'b11);
    m_frac = 1'b0; m_sat = 1'b0;
    chk3("err_clear", R_CTL, 16'h0000);

    // Low-byte-only write to OP2
    bus_wr(R_OP2, 16'hABCD, 2'b01);
    model_start(16'h00CD);
    wait_idle();
    chk3("byte_op2", R_OP2, 16'h00CD);
    check_results("byte_op2");

    // Unmapped offset and unselected address read 0
    bus_wr(4'd9, 16'hFFFF, 2'b11);
    chk3("unmapped", 4'd9, 16'h0000);
    bus_rd_addr(14'h0050);
    chk("unselected/sw8", r8, 16'h0000);

    // Reset mid-operation
    bus_wr(R_MACS, 16'h1111, 2'b11);
    bus_wr(R_OP2, 16'h2222, 2'b11);
    @(negedge mclk);
    puc_rst = 1'b1;
    @(negedge mclk);
    @(negedge mclk);
    puc_rst = 1'b0;
    model_reset();
    for (int i = 0; i <= 8; i++) chk3("midop_reset", 4'(i), 16'h0000);

    // Randomized operations against the reference model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          v = pick16();
          if ($urandom_range(0, 1) == 0) begin
            bus_wr(R_RESLO, v, 2'b11);
            m_res[15:0] = v;
          end else begin
            bus_wr(R_RESHI, v, 2'b11);
            m_res[31:16] = v;
          end
        end
        1: begin
          v = {14'h0000, 2'($urandom)};
          bus_wr(R_CTL, v, 2'b11);
          m_frac = v[0];
          m_sat  = v[1];
        end
        default: begin
          a = 4'($urandom_range(0, 3));
          run_op(a, pick16(), pick16());
          chk3("rnd_op1", 4'($urandom_range(0, 3)), m_op1);
        end
      endcase
      check_results("rnd");
      chk3("rnd_ctl", R_CTL, {12'h000, m_err, 1'b0, m_sat, m_frac});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
